// File: rtl/decode.sv
// Decode stage: register file, instruction decode, load-use detection
// and the registered D/E pipeline bundle.
module decode #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr_d,
  input  logic [DW-1:0] pc_d,
  input  logic [DW-1:0] pc_next_d,
  input  logic          flush_e,
  input  logic          we_w,
  input  logic [2:0]    waddr_w,
  input  logic [DW-1:0] wdata_w,
  output logic          stall_fd,
  output logic [DW-1:0] pc_e,
  output logic [DW-1:0] pc_next_e,
  output logic [DW-1:0] rd1_e,
  output logic [DW-1:0] rd2_e,
  output logic [DW-1:0] imm_e,
  output logic [2:0]    rd_e,
  output logic          reg_write_e,
  output logic          mem_write_e,
  output logic          mem_to_reg_e,
  output logic          branch_e,
  output logic          jump_e,
  output logic          alu_src_e,
  output logic          illegal_e,
  output logic [2:0]    alu_ctrl_e
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] pc_next;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [2:0]    rd;
    logic          reg_write;
    logic          mem_write;
    logic          mem_to_reg;
    logic          branch;
    logic          jump;
    logic          alu_src;
    logic          illegal;
    logic [2:0]    alu_ctrl;
  } de_t;

  logic [DW-1:0] regs [NREG];
  de_t d, q;

  logic [3:0] op;
  logic [2:0] rd, rs1, rs2, a2;
  logic       is_r, is_addi, is_lw, is_sw, is_beq, is_jmp;
  logic       uses_p2, hazard;
  logic [DW-1:0] rd1, rd2;

  assign op  = instr_d[15:12];
  assign rd  = instr_d[11:9];
  assign rs1 = instr_d[8:6];
  assign rs2 = instr_d[5:3];

  assign is_r    = op <= 4'd5;
  assign is_addi = op == 4'd6;
  assign is_lw   = op == 4'd7;
  assign is_sw   = op == 4'd8;
  assign is_beq  = op == 4'd9;
  assign is_jmp  = op == 4'd10;

  assign uses_p2 = is_r | is_sw | is_beq;
  assign a2      = (is_sw | is_beq) ? rd : rs2;

  // Write-through: a same-cycle writeback is visible to this decode.
  assign rd1 = (rs1 == 3'd0) ? '0 :
               (we_w && waddr_w == rs1) ? wdata_w : regs[rs1];
  assign rd2 = (a2 == 3'd0) ? '0 :
               (we_w && waddr_w == a2) ? wdata_w : regs[a2];

  assign hazard = q.mem_to_reg && q.rd != 3'd0 &&
                  (q.rd == rs1 || (uses_p2 && q.rd == a2));
  assign stall_fd = hazard & ~flush_e;

  always_comb begin
    d         = '0;
    d.pc      = pc_d;
    d.pc_next = pc_next_d;
    d.rd1     = rd1;
    d.rd2     = rd2;
    d.imm     = {{(DW-6){instr_d[5]}}, instr_d[5:0]};
    unique case (1'b1)
      is_r: begin
        d.reg_write = 1'b1;
        d.alu_ctrl  = op[2:0];
      end
      is_addi, is_lw: begin
        d.reg_write  = 1'b1;
        d.alu_src    = 1'b1;
        d.mem_to_reg = is_lw;
      end
      is_sw: begin
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
      end
      is_beq: begin
        d.branch   = 1'b1;
        d.alu_ctrl = 3'b001;
      end
      is_jmp: begin
        d.jump = 1'b1;
        d.imm  = {{(DW-12){instr_d[11]}}, instr_d[11:0]};
      end
      default: d.illegal = 1'b1;
    endcase
    d.rd = d.reg_write ? rd : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      if (we_w && waddr_w != 3'd0)
        regs[waddr_w] <= wdata_w;
      if (flush_e || hazard)
        q <= '0;
      else
        q <= d;
    end
  end

  assign pc_e         = q.pc;
  assign pc_next_e    = q.pc_next;
  assign rd1_e        = q.rd1;
  assign rd2_e        = q.rd2;
  assign imm_e        = q.imm;
  assign rd_e         = q.rd;
  assign reg_write_e  = q.reg_write;
  assign mem_write_e  = q.mem_write;
  assign mem_to_reg_e = q.mem_to_reg;
  assign branch_e     = q.branch;
  assign jump_e       = q.jump;
  assign alu_src_e    = q.alu_src;
  assign illegal_e    = q.illegal;
  assign alu_ctrl_e   = q.alu_ctrl;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed cases plus random traffic against
// an instruction-level reference model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_d, pc_d, pc_next_d;
  logic        flush_e, we_w;
  logic [2:0]  waddr_w;
  logic [15:0] wdata_w;
  logic        stall_fd;
  logic [15:0] pc_e, pc_next_e, rd1_e, rd2_e, imm_e;
  logic [2:0]  rd_e, alu_ctrl_e;
  logic        reg_write_e, mem_write_e, mem_to_reg_e;
  logic        branch_e, jump_e, alu_src_e, illegal_e;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d),
    .pc_next_d(pc_next_d), .flush_e(flush_e), .we_w(we_w),
    .waddr_w(waddr_w), .wdata_w(wdata_w), .stall_fd(stall_fd),
    .pc_e(pc_e), .pc_next_e(pc_next_e), .rd1_e(rd1_e),
    .rd2_e(rd2_e), .imm_e(imm_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .mem_to_reg_e(mem_to_reg_e), .branch_e(branch_e),
    .jump_e(jump_e), .alu_src_e(alu_src_e),
    .illegal_e(illegal_e), .alu_ctrl_e(alu_ctrl_e)
  );

  int nerr = 0;
  int nchk = 0;

  logic [15:0] m_regs [8];
  logic [15:0] m_pc, m_pcn, m_rd1, m_rd2, m_imm;
  logic [2:0]  m_rd;
  logic [9:0]  m_ctl;
  logic        last_stall;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rdv(int a);
    if (a == 0) return 16'h0;
    if (we_w && int'(waddr_w) == a) return wdata_w;
    return m_regs[a];
  endfunction

  function automatic logic [15:0] sext(int v, int bits);
    int x;
    x = v;
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return 16'(x);
  endfunction

  task automatic step();
    int op, f_rd, f_rs1, f_rs2, p2, iv;
    bit uses2, haz, stl;
    bit rw, mw, mtr, br, jp, asrc, ill;
    int alu;
    logic [15:0] n_rd1, n_rd2, n_imm;
    #1;
    iv    = int'(instr_d);
    op    = iv / 4096;
    f_rd  = (iv / 512) % 8;
    f_rs1 = (iv / 64) % 8;
    f_rs2 = (iv / 8) % 8;
    uses2 = (op <= 5) || op == 8 || op == 9;
    p2    = (op == 8 || op == 9) ? f_rd : f_rs2;
    haz   = m_ctl[7] && m_rd != 0 &&
            (int'(m_rd) == f_rs1 || (uses2 && int'(m_rd) == p2));
    stl   = haz && !flush_e;
    check("stall_fd", stall_fd, stl);
    {rw, mw, mtr, br, jp, asrc, ill} = '0;
    alu = 0;
    if (op <= 5) begin rw = 1; alu = op; end
    else if (op == 6) begin rw = 1; asrc = 1; end
    else if (op == 7) begin rw = 1; asrc = 1; mtr = 1; end
    else if (op == 8) begin asrc = 1; mw = 1; end
    else if (op == 9) begin br = 1; alu = 1; end
    else if (op == 10) jp = 1;
    else ill = 1;
    n_imm = (op == 10) ? sext(iv % 4096, 12) : sext(iv % 64, 6);
    n_rd1 = rdv(f_rs1);
    n_rd2 = rdv(p2);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      {m_pc, m_pcn, m_rd1, m_rd2, m_imm, m_rd, m_ctl} = '0;
    end else begin
      if (we_w && waddr_w != 0) m_regs[waddr_w] = wdata_w;
      if (flush_e || haz)
        {m_pc, m_pcn, m_rd1, m_rd2, m_imm, m_rd, m_ctl} = '0;
      else begin
        m_pc  = pc_d;
        m_pcn = pc_next_d;
        m_rd1 = n_rd1;
        m_rd2 = n_rd2;
        m_imm = n_imm;
        m_rd  = rw ? 3'(f_rd) : 3'd0;
        m_ctl = {rw, mw, mtr, br, jp, asrc, ill, 3'(alu)};
      end
    end
    last_stall = stl;
    #1;
    check("pc_e", pc_e, m_pc);
    check("pc_next_e", pc_next_e, m_pcn);
    check("rd1_e", rd1_e, m_rd1);
    check("rd2_e", rd2_e, m_rd2);
    check("imm_e", imm_e, m_imm);
    check("rd_e", rd_e, m_rd);
    check("ctl", {reg_write_e, mem_write_e, mem_to_reg_e, branch_e,
                  jump_e, alu_src_e, illegal_e, alu_ctrl_e}, m_ctl);
  endtask

  task automatic next_pc();
    pc_d      = pc_d + 16'd1;
    pc_next_d = pc_d + 16'd1;
  endtask

  task automatic issue(logic [15:0] ins, logic fl);
    instr_d = ins;
    flush_e = fl;
    step();
    we_w = 1'b0;
    for (int n = 0; n < 4 && last_stall; n++) step();
    flush_e = 1'b0;
    next_pc();
  endtask

  initial begin
    rst = 1'b1; instr_d = 16'h0; pc_d = 16'h0100; pc_next_d = 16'h0101;
    flush_e = 1'b0; we_w = 1'b0; waddr_w = 3'd0; wdata_w = 16'h0;
    last_stall = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    {m_pc, m_pcn, m_rd1, m_rd2, m_imm, m_rd, m_ctl} = '0;
    @(posedge clk);
    #1;

    step();
    step();
    check("rst_stall", stall_fd, 1'b0);
    check("rst_pc_e", pc_e, 16'h0);
    rst = 1'b0;

    issue(16'h6047, 1'b0);
    check("addi_rd1", rd1_e, 16'h0);
    check("addi_imm", imm_e, 16'h0007);
    check("addi_rd", rd_e, 3'd0);
    check("addi_rw", reg_write_e, 1'b1);

    we_w = 1; waddr_w = 3'd2; wdata_w = 16'h1234;
    issue(16'h1080, 1'b0);
    check("byp_rd1", rd1_e, 16'h1234);
    check("byp_alu", alu_ctrl_e, 3'b001);
    issue(16'h1080, 1'b0);
    check("r2_rd1", rd1_e, 16'h1234);
    we_w = 1; waddr_w = 3'd0; wdata_w = 16'hBEEF;
    issue(16'h1000, 1'b0);
    check("r0_byp", rd1_e, 16'h0);
    issue(16'h1000, 1'b0);
    check("r0_read", rd1_e, 16'h0);

    we_w = 1; waddr_w = 3'd3; wdata_w = 16'h0055;
    issue(16'h0000, 1'b0);
    we_w = 1; waddr_w = 3'd1; wdata_w = 16'h00A1;
    issue(16'h0000, 1'b0);
    we_w = 1; waddr_w = 3'd5; wdata_w = 16'h5555;
    issue(16'h0000, 1'b0);

    issue(16'h623F, 1'b0);
    check("addi_neg_imm", imm_e, 16'hFFFF);
    check("addi_asrc", alu_src_e, 1'b1);
    issue(16'hA800, 1'b0);
    check("jmp_imm", imm_e, 16'hF800);
    check("jmp_j", jump_e, 1'b1);
    issue(16'h7441, 1'b0);
    check("lw_mtr", mem_to_reg_e, 1'b1);
    check("lw_rd", rd_e, 3'd2);

    issue(16'h7600, 1'b0);
    instr_d = 16'h02C0;
    #1;
    check("lu_stall", stall_fd, 1'b1);
    step();
    check("lu_bubble", reg_write_e, 1'b0);
    step();
    check("lu_nostall", last_stall, 1'b0);
    check("lu_rd1", rd1_e, 16'h0055);
    check("lu_rd", rd_e, 3'd1);
    next_pc();

    issue(16'h7600, 1'b0);
    instr_d = 16'h0320;
    #1;
    check("r4_nostall", stall_fd, 1'b0);
    step();
    next_pc();

    issue(16'h1080, 1'b1);
    check("fl_rw", reg_write_e, 1'b0);
    check("fl_rd1", rd1_e, 16'h0);
    check("fl_pc", pc_e, 16'h0);
    issue(16'h7600, 1'b0);
    instr_d = 16'h02C0;
    flush_e = 1'b1;
    #1;
    check("fl_haz_stall", stall_fd, 1'b0);
    step();
    check("fl_haz_mtr", mem_to_reg_e, 1'b0);
    check("fl_haz_rd1", rd1_e, 16'h0);
    flush_e = 1'b0;
    next_pc();

    issue(16'hF123, 1'b0);
    check("ill", illegal_e, 1'b1);
    check("ill_rw", reg_write_e, 1'b0);
    issue(16'h8A41, 1'b0);
    check("sw_mw", mem_write_e, 1'b1);
    check("sw_rd2", rd2_e, 16'h5555);
    check("sw_rd", rd_e, 3'd0);
    issue(16'h9283, 1'b0);
    check("beq_br", branch_e, 1'b1);
    check("beq_alu", alu_ctrl_e, 3'b001);
    check("beq_rd2", rd2_e, 16'h00A1);

    for (int c = 0; c < 600; c++) begin
      if (!last_stall) begin
        instr_d = 16'($urandom);
        if ($urandom_range(0, 2) == 0)
          instr_d[15:12] = 4'd7;
        next_pc();
      end
      flush_e = ($urandom_range(0, 7) == 0);
      we_w    = 1'($urandom);
      waddr_w = 3'($urandom);
      wdata_w = 16'($urandom);
      rst     = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Decode stage of the 16-bit five-stage pipeline. It sits between fetch and execute, takes `instr_d`, `pc_d` and `pc_next_d` from fetch, and owns the 8×16 register file. It produces the registered D/E pipeline register: operands, immediate, destination and control. It also detects load-use hazards, stalls fetch/decode, and flushes itself when execute redirects the PC.

## Interface
- `DW`, 16: datapath / instruction width
- `NREG`, 8: register count (3-bit specifiers); r0 reads 0, writes ignored
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high
- `instr_d` in 16: instruction from fetch
- `pc_d` in 16: PC of `instr_d`
- `pc_next_d` in 16: `pc_d`+1 from fetch
- `flush_e` in 1: taken branch/jump in execute (driven by `pc_select_e`); squash D/E
- `we_w` in 1: writeback enable
- `waddr_w` in 3: writeback register
- `wdata_w` in 16: writeback data
- `stall_fd` out 1: combinational; hold fetch PC and F/D register this cycle
- `pc_e`, `pc_next_e` out 16: registered PCs
- `rd1_e`, `rd2_e` out 16: registered operands
- `imm_e` out 16: registered sign-extended immediate
- `rd_e` out 3: registered destination
- `reg_write_e`, `mem_write_e`, `mem_to_reg_e`, `branch_e`, `jump_e`, `alu_src_e`, `illegal_e` out 1: registered controls
- `alu_ctrl_e` out 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt

## Operation
- Fields: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0], imm12=[11:0].
- Opcodes:
  - 0–5 ADD/SUB/AND/OR/XOR/SLT: R-type; `rd`←rs1 op rs2; reg_write=1.
  - 6 ADDI: alu_src=1; imm=sext(imm6).
  - 7 LW: ADDI controls plus mem_to_reg=1.
  - 8 SW: alu_src=1; mem_write=1; reg_write=0; store data is reg[rd] on port 2.
  - 9 BEQ: branch=1; alu sub; compares reg[rd] (port 2) with reg[rs1]; imm=sext(imm6).
  - A JMP: jump=1; imm=sext(imm12); reg_write=0.
  - B–F: all controls 0; illegal_e=1.
- `0x0000` (ADD r0,r0,r0) is the canonical NOP. Bubble = all E outputs zero.
- Port 1 reads `rs1`. Port 2 reads `rd` for SW/BEQ, and `rs2` otherwise.
- `rd_e` = `rd` field for reg-writing ops, 0 otherwise.
- Register file:
  - Write on the rising edge when `we_w` and `waddr_w`≠0.
  - Same-cycle read of `waddr_w` returns `wdata_w` (write-through bypass). Reads of r0 return 0.
- Load-use hazard = `mem_to_reg_e` & `rd_e`≠0 & (`rd_e`==rs1, or `rd_e`==port-2 address when that op uses port 2).
- `stall_fd` = hazard & ~`flush_e`.
- `imm_e` for R-type: sext(imm6). Don't-care for execute; verification checks the exact value.

## Timing
- D/E register update priority each edge: `rst` > `flush_e` > hazard > normal.
  - `rst`: all outputs 0, register file cleared to 0.
  - `flush_e`: bubble.
  - hazard: bubble. Fetch holds via `stall_fd`, so the same `instr_d` re-decodes next cycle.
  - normal: capture the decode of `instr_d`.
- Latency: 1 cycle, `instr_d` → E outputs.
- Hazard stalls exactly one cycle, because the bubble clears `mem_to_reg_e`.
- `flush_e` together with hazard: bubble, and `stall_fd`=0 so fetch follows the redirect.
- `rst` asserted mid-operation: next edge zeroes everything regardless of other inputs. `stall_fd` is 0 while `mem_to_reg_e`=0.
- `stall_fd` is the only combinational output.

## Test plan
- Reset: `rst`=1 for 2 edges → all E outputs 0, `stall_fd`=0; instr 0x6047 (ADDI r0,r1,7) → rd1_e=0, imm_e=0x0007, rd_e=0, reg_write_e=1.
- Writeback plus bypass: we_w=1, waddr_w=2, wdata_w=0x1234 in the same cycle as instr 0x1080 (SUB r0,r2,r0) → rd1_e=0x1234, alu_ctrl_e=001; a later read of r2 still gives 0x1234; a write to r0 reads back 0.
- Immediates: ADDI 0x623F → imm_e=0xFFFF, alu_src_e=1; JMP 0xA800 → imm_e=0xF800, jump_e=1; LW 0x7441 → mem_to_reg_e=1, rd_e=2.
- Load-use: LW r3 (0x7600), then ADD r1,r3,r0 (0x02C0) → `stall_fd`=1 for one cycle; E shows a bubble, then the ADD with rd1_e = r3 content; no stall if the consumer reads r4 only.
- Flush: `flush_e`=1 with any instr → next E is all-zero; with a pending load-use hazard → `stall_fd`=0 and a bubble.
- Illegal/store/branch: 0xF123 → illegal_e=1 and other controls 0; SW 0x8A41 → mem_write_e=1, rd2_e = r5 content, rd_e=0; BEQ 0x9283 → branch_e=1, alu_ctrl_e=001, rd2_e = r1 content.
